// File: rtl/isr_push_ctrl.sv
// ISR push controller: IN autopush and explicit PUSH into the RX FIFO; optional drop counter under ISR_PUSH_DROP_CNT_EN.
// Strobes are same-cycle combinational; FIFO-full on autopush or blocking PUSH stalls the machine via WAIT_FULL.
module isr_push_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        penable,
   input  logic        in_req,
   input  logic        push_req,
   input  logic        push_iffull,
   input  logic        push_block,
   input  logic        autopush,
   input  logic [4:0]  thresh,
   input  logic [5:0]  shift_count,
   input  logic [31:0] push_dout,
   input  logic        fifo_full,
   output logic        isr_do_shift,
   output logic        isr_set,
   output logic [31:0] isr_din,
   output logic [5:0]  isr_bit_count,
   output logic        fifo_push,
   output logic [31:0] fifo_data,
   output logic        stall,
`ifdef ISR_PUSH_DROP_CNT_EN
   output logic [7:0]  drop_count,
`endif
   output logic        busy
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_FULL = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [5:0] thr;
   logic       reach;
   logic       act;
   logic       push_ok;
   logic       auto_hit;
   logic       push_hit;
   logic       drop_evt;

   assign thr      = (thresh == 5'd0) ? 6'd32 : {1'b0, thresh};
   assign reach    = (shift_count >= thr);
   assign act      = penable && !reset;
   assign push_ok  = !push_iffull || reach;
   assign auto_hit = in_req && autopush && reach;
   assign push_hit = !in_req && push_req && push_ok;
   assign drop_evt = act && push_hit && fifo_full && !push_block;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Without penable the machine is frozen, so a pending WAIT_FULL persists.
   always_comb begin
      state_nxt = state;
      if (reset) begin
         state_nxt = IDLE;
      end else if (penable) begin
         state_nxt = IDLE;
         if (auto_hit && fifo_full) begin
            state_nxt = WAIT_FULL;
         end else if (push_hit && fifo_full && push_block) begin
            state_nxt = WAIT_FULL;
         end
      end
   end

   always_comb begin
      isr_do_shift = 1'b0;
      isr_set      = 1'b0;
      fifo_push    = 1'b0;
      stall        = 1'b0;
      if (reset) begin
         stall = 1'b0;
      end else if (!penable) begin
         stall = (state == WAIT_FULL);
      end else if (in_req) begin
         if (auto_hit && fifo_full) begin
            stall = 1'b1;
         end else begin
            isr_do_shift = 1'b1;
            fifo_push    = auto_hit;
            isr_set      = auto_hit;
         end
      end else if (push_hit) begin
         if (!fifo_full) begin
            fifo_push = 1'b1;
            isr_set   = 1'b1;
         end else if (push_block) begin
            stall = 1'b1;
         end else begin
            isr_set = 1'b1;
         end
      end
   end

   assign isr_din       = 32'd0;
   assign isr_bit_count = 6'd0;
   assign fifo_data     = reset ? 32'd0 : push_dout;
   assign busy          = (state == WAIT_FULL) && !reset;

`ifdef ISR_PUSH_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= 8'd0;
      end else if (drop_evt && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop_evt & act;
`endif

endmodule

// File: tb/tb_isr_push_ctrl.sv
// Directed self-checking bench for isr_push_ctrl; define ISR_PUSH_DROP_CNT_EN to also check drop_count.
module tb_isr_push_ctrl;

   logic        clk;
   logic        reset;
   logic        penable;
   logic        in_req;
   logic        push_req;
   logic        push_iffull;
   logic        push_block;
   logic        autopush;
   logic [4:0]  thresh;
   logic [5:0]  shift_count;
   logic [31:0] push_dout;
   logic        fifo_full;
   logic        isr_do_shift;
   logic        isr_set;
   logic [31:0] isr_din;
   logic [5:0]  isr_bit_count;
   logic        fifo_push;
   logic [31:0] fifo_data;
   logic        stall;
   logic        busy;
`ifdef ISR_PUSH_DROP_CNT_EN
   logic [7:0]  drop_count;
`endif

   int checks = 0;
   int errors = 0;

   isr_push_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .penable      (penable),
      .in_req       (in_req),
      .push_req     (push_req),
      .push_iffull  (push_iffull),
      .push_block   (push_block),
      .autopush     (autopush),
      .thresh       (thresh),
      .shift_count  (shift_count),
      .push_dout    (push_dout),
      .fifo_full    (fifo_full),
      .isr_do_shift (isr_do_shift),
      .isr_set      (isr_set),
      .isr_din      (isr_din),
      .isr_bit_count(isr_bit_count),
      .fifo_push    (fifo_push),
      .fifo_data    (fifo_data),
      .stall        (stall),
`ifdef ISR_PUSH_DROP_CNT_EN
      .drop_count   (drop_count),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Order of expectations: shift, set, push, stall, busy.
   task automatic chk_out(input string tag, input logic e_shift, input logic e_set,
                          input logic e_push, input logic e_stall, input logic e_busy);
      chk({tag, ".shift"}, {31'd0, isr_do_shift}, {31'd0, e_shift});
      chk({tag, ".set"},   {31'd0, isr_set},      {31'd0, e_set});
      chk({tag, ".push"},  {31'd0, fifo_push},    {31'd0, e_push});
      chk({tag, ".stall"}, {31'd0, stall},        {31'd0, e_stall});
      chk({tag, ".busy"},  {31'd0, busy},         {31'd0, e_busy});
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   task automatic no_instr;
      in_req      = 1'b0;
      push_req    = 1'b0;
      push_iffull = 1'b0;
      push_block  = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      penable     = 1'b1;
      in_req      = 1'b1;
      push_req    = 1'b0;
      push_iffull = 1'b0;
      push_block  = 1'b0;
      autopush    = 1'b1;
      thresh      = 5'd8;
      shift_count = 6'd8;
      push_dout   = 32'hDEADBEEF;
      fifo_full   = 1'b0;

      // Reset with an otherwise pushing IN: everything must be silent.
      settle;
      chk_out("rst", 0, 0, 0, 0, 0);
      chk("rst.data", fifo_data, 32'd0);
      chk("rst.din", isr_din, 32'd0);
      chk("rst.cnt", {26'd0, isr_bit_count}, 32'd0);
      adv;
      settle;
      chk_out("rst2", 0, 0, 0, 0, 0);
`ifdef ISR_PUSH_DROP_CNT_EN
      chk("rst.drop", {24'd0, drop_count}, 32'd0);
`endif
      adv;
      reset = 1'b0;

      // Autopush at threshold 8 with 0xA5.
      push_dout = 32'h000000A5;
      settle;
      chk_out("ap8", 1, 1, 1, 0, 0);
      chk("ap8.data", fifo_data, 32'h000000A5);
      adv;

      // IN without autopush.
      autopush = 1'b0;
      settle;
      chk_out("in_noap", 1, 0, 0, 0, 0);
      adv;

      // Autopush below threshold.
      autopush    = 1'b1;
      shift_count = 6'd7;
      settle;
      chk_out("ap_below", 1, 0, 0, 0, 0);
      adv;

      // thresh=0 means 32: 31 bits does not reach.
      thresh      = 5'd0;
      shift_count = 6'd31;
      settle;
      chk_out("thr32_31", 1, 0, 0, 0, 0);
      adv;

      // 32-bit IN against a full FIFO for 3 cycles.
      shift_count = 6'd32;
      push_dout   = 32'h12345678;
      fifo_full   = 1'b1;
      settle;
      chk_out("full_c1", 0, 0, 0, 1, 0);
      adv;
      settle;
      chk_out("full_c2", 0, 0, 0, 1, 1);
      adv;
      settle;
      chk_out("full_c3", 0, 0, 0, 1, 1);
      adv;
      fifo_full = 1'b0;
      settle;
      chk_out("full_c4", 1, 1, 1, 0, 1);
      chk("full_c4.data", fifo_data, 32'h12345678);
      adv;
      no_instr;
      settle;
      chk_out("full_after", 0, 0, 0, 0, 0);
      adv;

      // PUSH iffull below threshold, then at threshold.
      autopush    = 1'b0;
      thresh      = 5'd16;
      shift_count = 6'd4;
      push_req    = 1'b1;
      push_iffull = 1'b1;
      settle;
      chk_out("iff_4", 0, 0, 0, 0, 0);
      adv;
      shift_count = 6'd16;
      settle;
      chk_out("iff_16", 0, 1, 1, 0, 0);
      adv;

      // Blocking PUSH into full FIFO, then penable low while FIFO drains.
      push_iffull = 1'b0;
      push_block  = 1'b1;
      fifo_full   = 1'b1;
      push_dout   = 32'hCAFE0001;
      settle;
      chk_out("blk_c1", 0, 0, 0, 1, 0);
      adv;
      fifo_full = 1'b0;
      penable   = 1'b0;
      settle;
      chk_out("pen0_a", 0, 0, 0, 1, 1);
      adv;
      settle;
      chk_out("pen0_b", 0, 0, 0, 1, 1);
      adv;
      penable = 1'b1;
      settle;
      chk_out("pen1", 0, 1, 1, 0, 1);
      chk("pen1.data", fifo_data, 32'hCAFE0001);
      adv;
      no_instr;
      settle;
      chk_out("pen1_after", 0, 0, 0, 0, 0);
      adv;

      // Reset pulse while a blocking PUSH waits.
      push_req   = 1'b1;
      push_block = 1'b1;
      fifo_full  = 1'b1;
      settle;
      chk_out("rstw_c1", 0, 0, 0, 1, 0);
      adv;
      settle;
      chk_out("rstw_c2", 0, 0, 0, 1, 1);
      adv;
      reset = 1'b1;
      settle;
      chk_out("rstw_rst", 0, 0, 0, 0, 0);
      chk("rstw_rst.data", fifo_data, 32'd0);
      adv;
      reset     = 1'b0;
      fifo_full = 1'b0;
      no_instr;
      settle;
      chk_out("rstw_post", 0, 0, 0, 0, 0);
      adv;

      // Preempted instruction in WAIT_FULL.
      autopush    = 1'b1;
      thresh      = 5'd4;
      shift_count = 6'd4;
      in_req      = 1'b1;
      fifo_full   = 1'b1;
      settle;
      chk_out("pre_c1", 0, 0, 0, 1, 0);
      adv;
      in_req = 1'b0;
      settle;
      chk_out("pre_c2", 0, 0, 0, 0, 1);
      adv;
      settle;
      chk_out("pre_c3", 0, 0, 0, 0, 0);
      adv;

      // penable low in IDLE with an IN pending: nothing happens.
      penable   = 1'b0;
      in_req    = 1'b1;
      fifo_full = 1'b0;
      settle;
      chk_out("pen0_idle", 0, 0, 0, 0, 0);
      adv;
      penable = 1'b1;
      in_req  = 1'b0;

      // Non-blocking PUSH into full FIFO, 300 times.
      autopush  = 1'b0;
      push_req  = 1'b1;
      fifo_full = 1'b1;
      for (int i = 0; i < 300; i++) begin
         settle;
         chk("drop.push", {31'd0, fifo_push}, 32'd0);
         chk("drop.set", {31'd0, isr_set}, 32'd1);
         chk("drop.stall", {31'd0, stall}, 32'd0);
         adv;
`ifdef ISR_PUSH_DROP_CNT_EN
         if (i == 0) chk("drop.cnt1", {24'd0, drop_count}, 32'd1);
`endif
      end
`ifdef ISR_PUSH_DROP_CNT_EN
      settle;
      chk("drop.sat", {24'd0, drop_count}, 32'd255);
`endif
      no_instr;
      settle;
      chk_out("end", 0, 0, 0, 0, 0);
      chk("end.din", isr_din, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
